alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
// - Execute->writeback stage directly downstream of the ALU: captures alu_out/carry_out per op, derives N/Z/C/V flags
// - 2-entry elastic buffer with valid/ready on both sides; absorbs one cycle of writeback back-pressure without bubbles
// - Feeds register-file write port (data + dest address) and branch/compare logic (flags)
// PARAMETERS
// - ALU_SIZE    16  datapath width; must match ALU instance; >=2
// - REG_ADDR_W  4   destination register address width
// PORTS
// - clk         in   1           rising-edge clock
// - rst_n       in   1           asynchronous active-low reset
// - in_valid    in   1           ALU result presented this cycle
// - in_ready    out  1           stage can accept (registered, no comb path from wb_ready)
// - alu_out     in   ALU_SIZE    ALU result
// - carry_out   in   1           ALU carry (A+B carry, always computed)
// - alu_sel     in   4           op code that produced alu_out
// - op_a_msb    in   1           MSB of ALU operand A (for overflow)
// - op_b_msb    in   1           MSB of ALU operand B
// - dest_addr   in   REG_ADDR_W  destination register
// - wb_valid    out  1           head entry valid
// - wb_ready    in   1           writeback consumes head this cycle
// - wb_data     out  ALU_SIZE    head result
// - wb_addr     out  REG_ADDR_W  head destination
// - wb_flags    out  4           head flags {N,Z,C,V}
// - sticky_clr  in   1           clear sticky flags (see CONFIGURATION)
// - sticky_flags out 4           accumulated {N,Z,C,V} (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, rst_n=0): occupancy 0, state EMPTY, both entries and all outputs 0, in_ready=1 after release
// - Push = in_valid&in_ready; pop = wb_valid&wb_ready; FIFO order strictly preserved
// - States: EMPTY(0) -push-> ONE; ONE -push&!pop-> FULL, -pop&!push-> EMPTY, push&pop-> ONE; FULL -pop-> ONE
// - FULL ignores in_valid (in_ready=0); push in FULL impossible by construction
// - in_ready = (state!=FULL); wb_valid = (state!=EMPTY); both decoded from state register only
// - Latency: entry pushed in cycle n appears on wb_* in cycle n+1 when buffer was EMPTY or popping in n
// - Flags computed at push, stored per entry, all 1-bit:
//   - N = alu_out[ALU_SIZE-1]; Z = (alu_out==0)
//   - C = carry_out if alu_sel==4'b0000 (add), else 0
//   - V add (0000): op_a_msb==op_b_msb && N!=op_a_msb; sub (0001): op_a_msb!=op_b_msb && N!=op_a_msb; else 0
// - wb_data/wb_addr/wb_flags driven 0 whenever wb_valid=0
// - Reset mid-operation drops all buffered entries; no partial writeback
// CONFIGURATION
// - Macro ALU_RESULT_STICKY_EN
// - Defined: sticky_flags |= flags of each popped entry, registered; sticky_clr=1 zeroes it next cycle;
//   clear and pop in same cycle -> result = flags of that pop only (clear applies first); reset value 0
// - Undefined: sticky_flags tied 4'b0, sticky_clr ignored, no sticky register synthesized
// TESTING
// - Reset mid-stream with 2 entries -> wb_valid=0, in_ready=1, wb_data=0, sticky_flags=0
// - Push alu_out=16'h0000, sel=0001, a_msb=0,b_msb=0, wb_ready=1 -> next cycle wb_valid=1, wb_flags=4'b0100
// - Add sel=0000, alu_out=16'h8000, carry=0, a_msb=0,b_msb=0 -> wb_flags=4'b1001 (N,V)
// - Add sel=0000, alu_out=16'h0001, carry=1 -> wb_flags=4'b0010; same data with sel=1000 -> 4'b0000
// - wb_ready=0, push 3 back-to-back (addr 1,2,3) -> third stalls (in_ready=0 after 2); release -> pops 1,2,3 in order
// - STICKY_EN: pop flags 4'b0010 then 4'b1000 -> sticky=4'b1010; sticky_clr with pop 4'b0100 -> 4'b0100

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute->writeback result stage.
// Captures ALU result and destination per op, derives {N,Z,C,V} at push and
// holds up to two entries so one cycle of writeback back-pressure costs no bubble.
// Optional sticky flag accumulator: define ALU_RESULT_STICKY_EN to build it;
// otherwise sticky_flags is tied to zero and sticky_clr is ignored.
module alu_result_stage #(
  parameter int unsigned ALU_SIZE   = 16,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_SIZE-1:0]   alu_out,
  input  logic                  carry_out,
  input  logic [3:0]            alu_sel,
  input  logic                  op_a_msb,
  input  logic                  op_b_msb,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ALU_SIZE-1:0]   wb_data,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [3:0]            wb_flags,
  input  logic                  sticky_clr,
  output logic [3:0]            sticky_flags
);

  localparam int unsigned ENTRY_W = ALU_SIZE + REG_ADDR_W + 4;

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic [ENTRY_W-1:0]   tail_q, tail_d;
  logic [ENTRY_W-1:0]   new_entry;
  logic [3:0]           new_flags;
  logic                 flag_n, flag_z, flag_c, flag_v;
  logic                 push, pop;

  always_comb begin
    flag_n = alu_out[ALU_SIZE-1];
    flag_z = (alu_out == '0);
    flag_c = (alu_sel == SEL_ADD) & carry_out;
    flag_v = 1'b0;
    case (alu_sel)
      SEL_ADD: flag_v = (op_a_msb == op_b_msb) && (flag_n != op_a_msb);
      SEL_SUB: flag_v = (op_a_msb != op_b_msb) && (flag_n != op_a_msb);
      default: flag_v = 1'b0;
    endcase
    new_flags = {flag_n, flag_z, flag_c, flag_v};
    new_entry = {alu_out, dest_addr, new_flags};
  end

  assign in_ready = (state_q != FULL);
  assign wb_valid = (state_q != EMPTY);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Head always holds the oldest entry; vacated slots are zeroed.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = new_entry;
            state_d = FULL;
          end
          2'b01: begin
            head_d  = '0;
            state_d = EMPTY;
          end
          2'b11:   head_d = new_entry;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign wb_data  = wb_valid ? head_q[ENTRY_W-1 -: ALU_SIZE]     : '0;
  assign wb_addr  = wb_valid ? head_q[REG_ADDR_W+3 -: REG_ADDR_W] : '0;
  assign wb_flags = wb_valid ? head_q[3:0]                        : '0;

`ifdef ALU_RESULT_STICKY_EN
  logic [3:0] sticky_q, sticky_d;

  // Clear takes effect before the OR, so a same-cycle pop survives the clear.
  always_comb begin
    sticky_d = sticky_clr ? 4'b0000 : sticky_q;
    if (pop) sticky_d = sticky_d | head_q[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expected values.
module tb_alu_result_stage;

  localparam int unsigned ALU_SIZE   = 16;
  localparam int unsigned REG_ADDR_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [ALU_SIZE-1:0]   alu_out;
  logic                  carry_out;
  logic [3:0]            alu_sel;
  logic                  op_a_msb;
  logic                  op_b_msb;
  logic [REG_ADDR_W-1:0] dest_addr;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ALU_SIZE-1:0]   wb_data;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [3:0]            wb_flags;
  logic                  sticky_clr;
  logic [3:0]            sticky_flags;

  int n_vec = 0;
  int n_err = 0;

  alu_result_stage #(
    .ALU_SIZE  (ALU_SIZE),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_out     (alu_out),
    .carry_out   (carry_out),
    .alu_sel     (alu_sel),
    .op_a_msb    (op_a_msb),
    .op_b_msb    (op_b_msb),
    .dest_addr   (dest_addr),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_addr     (wb_addr),
    .wb_flags    (wb_flags),
    .sticky_clr  (sticky_clr),
    .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic c,
                        input logic [3:0] sel, input logic a, input logic b,
                        input logic [3:0] addr);
    in_valid  = v;
    alu_out   = d;
    carry_out = c;
    alu_sel   = sel;
    op_a_msb  = a;
    op_b_msb  = b;
    dest_addr = addr;
  endtask

  task automatic check_head(input string tag, input logic [15:0] d,
                            input logic [3:0] addr, input logic [3:0] fl);
    check({tag, ".valid"}, 32'(wb_valid), 32'd1);
    check({tag, ".data"},  32'(wb_data),  32'(d));
    check({tag, ".addr"},  32'(wb_addr),  32'(addr));
    check({tag, ".flags"}, 32'(wb_flags), 32'(fl));
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, 32'(wb_valid), 32'd0);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    check({tag, ".data"},  32'(wb_data),  32'd0);
    check({tag, ".flags"}, 32'(wb_flags), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    wb_ready   = 1'b0;
    sticky_clr = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    repeat (2) cyc();
    check_empty("reset");
    check("reset.sticky", 32'(sticky_flags), 32'd0);
    rst_n = 1'b1;
    cyc();
    check_empty("post_reset");

    // Streaming vectors with wb_ready held high: each appears one cycle after push.
    wb_ready = 1'b1;
    set_in(1'b1, 16'h0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'h5);   // sub zero
    cyc();
    check_head("sub_zero", 16'h0000, 4'h5, 4'b0100);
    set_in(1'b1, 16'h8000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h6);   // add pos+pos -> neg
    cyc();
    check_head("add_ovf", 16'h8000, 4'h6, 4'b1001);
    set_in(1'b1, 16'h0001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h7);   // add with carry
    cyc();
    check_head("add_carry", 16'h0001, 4'h7, 4'b0010);
    set_in(1'b1, 16'h0001, 1'b1, 4'b1000, 1'b0, 1'b0, 4'h8);   // non-arith op
    cyc();
    check_head("logic_op", 16'h0001, 4'h8, 4'b0000);
    set_in(1'b1, 16'h8000, 1'b1, 4'b0001, 1'b0, 1'b1, 4'h9);   // sub pos-neg -> neg
    cyc();
    check_head("sub_ovf", 16'h8000, 4'h9, 4'b1001);
    set_in(1'b1, 16'h7FFF, 1'b1, 4'b0000, 1'b1, 1'b1, 4'hA);   // add neg+neg -> pos
    cyc();
    check_head("add_negovf", 16'h7FFF, 4'hA, 4'b0011);
    check("stream.in_ready", 32'(in_ready), 32'd1);
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    cyc();
    check_empty("drain");

    // Back-pressure: third push must stall until the head is consumed.
    wb_ready = 1'b0;
    set_in(1'b1, 16'h0011, 1'b0, 4'b1000, 1'b0, 1'b0, 4'h1);
    cyc();
    check("bp1.ready", 32'(in_ready), 32'd1);
    check_head("bp1", 16'h0011, 4'h1, 4'b0000);
    set_in(1'b1, 16'h0022, 1'b0, 4'b1000, 1'b0, 1'b0, 4'h2);
    cyc();
    check("bp2.ready", 32'(in_ready), 32'd0);
    check_head("bp2", 16'h0011, 4'h1, 4'b0000);
    set_in(1'b1, 16'h0033, 1'b0, 4'b1000, 1'b0, 1'b0, 4'h3);
    cyc();
    check("bp3.ready", 32'(in_ready), 32'd0);
    check_head("bp3_stall", 16'h0011, 4'h1, 4'b0000);
    wb_ready = 1'b1;
    cyc();
    check("pop1.ready", 32'(in_ready), 32'd1);
    check_head("pop1", 16'h0022, 4'h2, 4'b0000);
    cyc();
    check_head("pop2", 16'h0033, 4'h3, 4'b0000);
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    cyc();
    check_empty("pop3");

`ifdef ALU_RESULT_STICKY_EN
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    check("sticky.clr", 32'(sticky_flags), 32'd0);
    set_in(1'b1, 16'h0001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h4);   // flags 0010
    cyc();
    set_in(1'b1, 16'h8000, 1'b0, 4'b1000, 1'b0, 1'b0, 4'h5);   // flags 1000
    cyc();
    check("sticky.first", 32'(sticky_flags), 32'b0010);
    set_in(1'b1, 16'h0000, 1'b0, 4'b0001, 1'b0, 1'b0, 4'h6);   // flags 0100
    cyc();
    check("sticky.accum", 32'(sticky_flags), 32'b1010);
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    check("sticky.clr_pop", 32'(sticky_flags), 32'b0100);
`else
    sticky_clr = 1'b1;
    set_in(1'b1, 16'h8001, 1'b1, 4'b0000, 1'b1, 1'b1, 4'h4);
    cyc();
    cyc();
    sticky_clr = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    cyc();
    check("sticky.tied", 32'(sticky_flags), 32'd0);
`endif

    // Reset with two entries buffered drops both.
    wb_ready = 1'b0;
    set_in(1'b1, 16'h00AA, 1'b1, 4'b0000, 1'b0, 1'b0, 4'hB);
    cyc();
    set_in(1'b1, 16'h00BB, 1'b1, 4'b0000, 1'b0, 1'b0, 4'hC);
    cyc();
    check("pre_rst.ready", 32'(in_ready), 32'd0);
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b0;
    #1;
    check_empty("mid_reset");
    check("mid_reset.sticky", 32'(sticky_flags), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_empty("after_reset");
    wb_ready = 1'b1;
    set_in(1'b1, 16'h1234, 1'b0, 4'b0001, 1'b1, 1'b0, 4'hD);   // sub neg-pos -> pos: V
    cyc();
    check_head("restart", 16'h1234, 4'hD, 4'b0001);
    set_in(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
    cyc();
    check_empty("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
